// File: rtl/mvf_sched_pkg.sv
// mvf_sched_pkg: shared types, widths and the round-robin picker for the channel scheduler.
package mvf_sched_pkg;

    localparam int DW = 32;
    localparam int MAX_CH = 8;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ARB, S_ISSUE, S_WAIT} state_t;

    // First set bit of pend at or after ptr, wrapping within n channels.
    function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] pend, input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        int idx;
        pick = ptr;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = int'(ptr) + i;
                if (idx >= n) idx = idx - n;
                if (pend[3'(idx)]) pick = 3'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mvf_trig_div.sv
// mvf_trig_div: registered tick on every DIV_FACTOR-th trig pulse; DIV_FACTOR <= 1 passes trig through.
module mvf_trig_div #(
    parameter int DIV_FACTOR = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_trig,
    output logic o_tick
);

    logic [5:0] r_cnt;
    logic       r_tick;
    logic       w_last;

    assign w_last = r_cnt == 6'(DIV_FACTOR - 1);
    assign o_tick = r_tick;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (DIV_FACTOR <= 1) begin
            r_tick <= i_trig;
        end else begin
            r_tick <= i_trig && w_last;
            if (i_trig) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mvf_ch_scheduler.sv
// mvf_ch_scheduler: round-robin sharing of one moving-average datapath across N_CH channels.
// Define MVF_SCHED_TIMEOUT_EN to add a WAIT watchdog of TMO_CYC cycles.
module mvf_ch_scheduler
    import mvf_sched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DIV_FACTOR = 4,
    parameter int WIN_LOG2   = 13,
    parameter int TMO_CYC    = 64,
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW = IW + WIN_LOG2
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_trig,
    input  logic [N_CH-1:0]    i_ch_en,
    input  logic               i_soft_clr,
    input  logic [N_CH*DW-1:0] i_din,
    output logic               o_mv_start,
    output logic               o_mv_clr,
    output logic [AW-1:0]      o_mv_addr,
    output logic [IW-1:0]      o_mv_ch,
    output logic [DW-1:0]      o_mv_din,
    input  logic               i_mv_done,
    input  logic [DW-1:0]      i_mv_dout,
    output logic [N_CH*DW-1:0] o_dout,
    output logic [N_CH-1:0]    o_dout_vld,
    output logic               o_busy,
    output logic [N_CH-1:0]    o_overrun
);

    localparam logic [AW-1:0] CLR_LAST = AW'(N_CH * (1 << WIN_LOG2) - 1);

    if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
        $error("N_CH out of range");
    end
    if (TMO_CYC < 1) begin : g_bad_tmo
        $error("TMO_CYC must be positive");
    end

    state_t             r_state, w_next;
    logic [AW-1:0]      r_clr_addr;
    logic [N_CH-1:0]    r_pend, r_ovr, r_vld;
    logic [IW-1:0]      r_gnt, r_rr, w_pick;
    logic [DW-1:0]      r_cap [N_CH];
    logic [N_CH*DW-1:0] r_dout;
    logic               r_sclr_q;
    logic               w_tick_raw, w_tick, w_enter_clr, w_tmo;

    mvf_trig_div #(.DIV_FACTOR(DIV_FACTOR)) u_div (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_trig (i_trig),
        .o_tick (w_tick_raw)
    );

    // Ticks landing in the sweep are dropped so the cleared buffers start empty.
    assign w_tick      = w_tick_raw && r_state != S_CLEAR;
    assign w_pick      = IW'(rr_pick(MAX_CH'(r_pend), 3'(r_rr), N_CH));
    assign w_enter_clr = r_state == S_IDLE && w_next == S_CLEAR;

`ifdef MVF_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] r_tmo;
    assign w_tmo = r_state == S_WAIT && !i_mv_done && r_tmo == TW'(TMO_CYC - 1);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_tmo <= '0;
        else r_tmo <= (r_state == S_WAIT && !i_mv_done && !w_tmo) ? r_tmo + 1'b1 : '0;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: w_next = (r_clr_addr == CLR_LAST) ? S_IDLE : S_CLEAR;
            S_IDLE:  w_next = (|r_pend) ? S_ARB : r_sclr_q ? S_CLEAR : S_IDLE;
            S_ARB:   w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = i_mv_done ? ((|r_pend) ? S_ARB : S_IDLE) : w_tmo ? S_IDLE : S_WAIT;
            default: w_next = S_CLEAR;
        endcase
    end

    assign o_mv_start = r_state == S_ISSUE;
    assign o_mv_clr   = r_state == S_CLEAR;
    assign o_mv_addr  = o_mv_clr ? r_clr_addr : {r_gnt, {WIN_LOG2{1'b0}}};
    assign o_mv_ch    = r_gnt;
    assign o_mv_din   = r_cap[r_gnt];
    assign o_busy     = r_state != S_IDLE;
    assign o_dout     = r_dout;
    assign o_dout_vld = r_vld;
    assign o_overrun  = r_ovr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_pend     <= '0;
            r_ovr      <= '0;
            r_vld      <= '0;
            r_gnt      <= '0;
            r_rr       <= '0;
            r_dout     <= '0;
            r_sclr_q   <= 1'b0;
            for (int k = 0; k < N_CH; k++) r_cap[k] <= '0;
        end else begin
            r_state    <= w_next;
            r_clr_addr <= w_enter_clr ? '0 : (r_state == S_CLEAR) ? r_clr_addr + 1'b1 : r_clr_addr;
            r_sclr_q   <= (r_sclr_q | i_soft_clr) & ~w_enter_clr;
            r_vld      <= '0;
            if (r_state == S_ARB) begin
                r_gnt <= w_pick;
                r_rr  <= (w_pick == IW'(N_CH - 1)) ? '0 : w_pick + 1'b1;
            end
            if (r_state == S_ISSUE) r_pend[r_gnt] <= 1'b0;
            if (r_state == S_WAIT && i_mv_done) begin
                r_dout[r_gnt*DW +: DW] <= i_mv_dout;
                r_vld[r_gnt]           <= 1'b1;
            end
            if (w_tmo) r_ovr[r_gnt] <= 1'b1;
            // Later assignments win: a tick re-arms a channel even while it is being issued.
            for (int k = 0; k < N_CH; k++) begin
                if (w_tick && i_ch_en[k]) begin
                    r_cap[k]  <= i_din[k*DW +: DW];
                    r_pend[k] <= 1'b1;
                    if (r_pend[k]) r_ovr[k] <= 1'b1;
                end
            end
            if (w_enter_clr) r_ovr <= '0;
        end
    end

endmodule

// File: tb/tb_mvf_ch_scheduler.sv
// tb_mvf_ch_scheduler: scoreboard bench for the scheduler with N_CH=4, DIV_FACTOR=4, WIN_LOG2=4.
module tb_mvf_ch_scheduler;

    typedef struct {
        int          ch;
        logic [31:0] val;
    } exp_t;

    logic         clk = 1'b0, n_rst = 1'b0, trig = 1'b0, soft_clr = 1'b0;
    logic [3:0]   ch_en = '0;
    logic [127:0] din = '0;
    logic         mv_start, mv_clr, mv_done = 1'b0, busy;
    logic [5:0]   mv_addr;
    logic [1:0]   mv_ch;
    logic [31:0]  mv_din, mv_dout = '0, resp_d;
    logic [127:0] dout, snap;
    logic [3:0]   dout_vld, overrun;
    int           n_chk = 0, n_fail = 0;
    int           vld_cnt [4];
    exp_t         iss_q[$], res_q[$];
    exp_t         e_iss, e_res;
    bit           hold_done = 0, drop_done = 0;

    always #5 clk = ~clk;

    mvf_ch_scheduler #(.N_CH(4), .DIV_FACTOR(4), .WIN_LOG2(4), .TMO_CYC(64)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_trig     (trig),
        .i_ch_en    (ch_en),
        .i_soft_clr (soft_clr),
        .i_din      (din),
        .o_mv_start (mv_start),
        .o_mv_clr   (mv_clr),
        .o_mv_addr  (mv_addr),
        .o_mv_ch    (mv_ch),
        .o_mv_din   (mv_din),
        .i_mv_done  (mv_done),
        .i_mv_dout  (mv_dout),
        .o_dout     (dout),
        .o_dout_vld (dout_vld),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    // Datapath stand-in: result is the sample plus one, two cycles after the issue strobe.
    initial forever begin
        @(negedge clk);
        if (n_rst && mv_start) begin
            resp_d = mv_din;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 2000 && hold_done; i++) @(negedge clk);
            if (!drop_done) begin
                mv_dout = resp_d + 1;
                mv_done = 1'b1;
                @(negedge clk);
                mv_done = 1'b0;
            end
        end
    end

    // Scoreboard: issue strobes and result pulses are popped in order and compared.
    initial forever begin
        @(negedge clk);
        if (n_rst && mv_start) begin
            n_chk++;
            if (iss_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue: unexpected mv_start ch=%0d din=%0d", mv_ch, mv_din);
            end else begin
                e_iss = iss_q.pop_front();
                if (mv_ch !== 2'(e_iss.ch) || mv_din !== e_iss.val || mv_addr !== {2'(e_iss.ch), 4'b0}) begin
                    n_fail++;
                    $display("FAIL issue: got ch=%0d din=%0d addr=%0d, expected ch=%0d din=%0d addr=%0d",
                             mv_ch, mv_din, mv_addr, e_iss.ch, e_iss.val, e_iss.ch * 16);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (n_rst && dout_vld[k]) begin
                n_chk++;
                vld_cnt[k]++;
                if (res_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result: unexpected dout_vld on ch%0d dout=%0d", k, dout[k*32 +: 32]);
                end else begin
                    e_res = res_q.pop_front();
                    if (e_res.ch != k || dout[k*32 +: 32] !== e_res.val) begin
                        n_fail++;
                        $display("FAIL result: got ch%0d dout=%0d, expected ch%0d dout=%0d",
                                 k, dout[k*32 +: 32], e_res.ch, e_res.val);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog timeout");
    end

    task automatic push(input int ch, input logic [31:0] val);
        iss_q.push_back('{ch, val});
        res_q.push_back('{ch, val + 1});
    endtask

    task automatic send_tick(input logic [3:0] en, input logic [31:0] d0, d1, d2, d3);
        ch_en = en;
        din   = {d3, d2, d1, d0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) trig = 1'b1;
            @(negedge clk) trig = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy && iss_q.size() == 0 && res_q.size() == 0) break;
        end
        n_chk++;
        if (i >= 500) begin
            n_fail++;
            $display("FAIL %s drain: busy=%0b issues_left=%0d results_left=%0d, expected idle with none left",
                     nm, busy, iss_q.size(), res_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic sweep_check(input string nm);
        int cyc, bad;
        cyc = 0;
        bad = 0;
        while (mv_clr && cyc < 200) begin
            if (mv_addr !== 6'(cyc)) bad++;
            cyc++;
            @(negedge clk);
        end
        n_chk++;
        if (cyc != 64) begin
            n_fail++;
            $display("FAIL %s sweep length: got %0d cycles, expected 64", nm, cyc);
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s sweep address: %0d addresses out of sequence, expected 0", nm, bad);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle after sweep: busy=%0b, expected 0", nm, busy);
        end
    endtask

    task automatic reset_dut(input string nm);
        @(negedge clk) n_rst = 1'b0;
        #1;
        n_chk++;
        if ({dout_vld, overrun, mv_start} !== 9'b0 || dout !== '0 || mv_din !== '0) begin
            n_fail++;
            $display("FAIL %s outputs in reset: vld=%b ovr=%b start=%b dout=%h din=%h, expected all 0",
                     nm, dout_vld, overrun, mv_start, dout, mv_din);
        end
        @(negedge clk) n_rst = 1'b1;
        #1;
        sweep_check(nm);
    endtask

    task automatic soft_clear_start(input string nm);
        int i;
        @(negedge clk) soft_clr = 1'b1;
        @(negedge clk) soft_clr = 1'b0;
        for (i = 0; i < 10 && !mv_clr; i++) @(negedge clk);
        n_chk++;
        if (mv_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL %s soft_clr sweep start: mv_clr=%0b, expected 1", nm, mv_clr);
        end
    endtask

    task automatic test_reset();
        reset_dut("t1_reset");
    endtask

    task automatic test_div_round_robin();
        for (int k = 0; k < 4; k++) vld_cnt[k] = 0;
        for (int k = 0; k < 4; k++) push(k, 32'(10 * (k + 1)));
        ch_en = 4'hF;
        din   = {32'd40, 32'd30, 32'd20, 32'd10};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) trig = 1'b1;
            @(negedge clk) trig = 1'b0;
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t2 early tick: busy=%0b after 3 trigs, expected 0", busy);
        end
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        drain("t2_round1");
        for (int k = 0; k < 4; k++) push(k, 32'(10 * (k + 1)));
        send_tick(4'hF, 10, 20, 30, 40);
        drain("t2_round2");
        n_chk++;
        if (dout !== {32'd41, 32'd31, 32'd21, 32'd11}) begin
            n_fail++;
            $display("FAIL t2 dout: got %h, expected {41,31,21,11}", dout);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (vld_cnt[k] != 2) begin
                n_fail++;
                $display("FAIL t2 vld count ch%0d: got %0d pulses, expected 2", k, vld_cnt[k]);
            end
        end
    endtask

    task automatic test_enable_mask();
        reset_dut("t3_reset");
        push(0, 101);
        push(2, 103);
        send_tick(4'b0101, 101, 102, 103, 104);
        drain("t3");
        n_chk++;
        if (dout !== {32'd0, 32'd104, 32'd0, 32'd102} || overrun !== 4'b0) begin
            n_fail++;
            $display("FAIL t3 mask: dout=%h ovr=%b, expected dout={0,104,0,102} ovr=0000", dout, overrun);
        end
    endtask

    task automatic test_overrun();
        reset_dut("t4_reset");
        hold_done = 1;
        push(0, 1000);
        send_tick(4'hF, 1000, 1001, 1002, 1003);
        push(1, 2001);
        push(2, 2002);
        push(3, 2003);
        push(0, 2000);
        send_tick(4'hF, 2000, 2001, 2002, 2003);
        n_chk++;
        if (overrun !== 4'b1110) begin
            n_fail++;
            $display("FAIL t4 overrun set: got %b, expected 1110", overrun);
        end
        hold_done = 0;
        drain("t4");
        n_chk++;
        if (overrun !== 4'b1110 || dout !== {32'd2004, 32'd2003, 32'd2002, 32'd2001}) begin
            n_fail++;
            $display("FAIL t4 after drain: ovr=%b dout=%h, expected ovr=1110 dout={2004,2003,2002,2001}", overrun, dout);
        end
        soft_clear_start("t4");
        n_chk++;
        if (overrun !== 4'b0) begin
            n_fail++;
            $display("FAIL t4 overrun clear: got %b, expected 0000", overrun);
        end
        sweep_check("t4_soft_clr");
    endtask

    task automatic test_clear_tick();
        int i;
        snap = dout;
        soft_clear_start("clr_tick");
        send_tick(4'hF, 9, 9, 9, 9);
        for (i = 0; i < 100 && busy; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || dout !== snap || overrun !== 4'b0) begin
            n_fail++;
            $display("FAIL clr_tick ignored: busy=%0b ovr=%b dout=%h, expected busy=0 ovr=0000 dout=%h",
                     busy, overrun, dout, snap);
        end
    endtask

    task automatic test_rr_fairness();
        reset_dut("t5_reset");
        push(1, 51);
        send_tick(4'b0010, 50, 51, 52, 53);
        drain("t5_setup");
        push(3, 63);
        push(0, 60);
        push(1, 61);
        send_tick(4'b1011, 60, 61, 62, 63);
        drain("t5");
        n_chk++;
        if (dout !== {32'd64, 32'd0, 32'd62, 32'd61}) begin
            n_fail++;
            $display("FAIL t5 dout: got %h, expected {64,0,62,61}", dout);
        end
    endtask

`ifdef MVF_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int i, cyc;
        reset_dut("t6_reset");
        drop_done = 1;
        iss_q.push_back('{0, 77});
        send_tick(4'b0001, 77, 0, 0, 0);
        for (i = 0; i < 20 && !mv_start; i++) @(negedge clk);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        n_chk++;
        if (cyc != 64 || overrun !== 4'b0001 || dout !== '0) begin
            n_fail++;
            $display("FAIL t6 timeout: wait=%0d ovr=%b dout=%h, expected wait=64 ovr=0001 dout=0", cyc, overrun, dout);
        end
        repeat (4) @(negedge clk);
        drop_done = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_div_round_robin();
        test_enable_mask();
        test_overrun();
        test_clear_tick();
        test_rr_fairness();
`ifdef MVF_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        n_chk++;
        if (iss_q.size() != 0 || res_q.size() != 0) begin
            n_fail++;
            $display("FAIL final queues: issues_left=%0d results_left=%0d, expected 0", iss_q.size(), res_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
